// File: rtl/guess_evaluator.sv
// guess_evaluator
// ---------------------------------------------------------------------------
// Sequential mastermind scorer for the safe-cracking game. A submit pulse
// latches the player's guess and the secret code, then the block walks the
// digits (building per-symbol histograms and counting exact hits), walks the
// symbol alphabet (summing min(hist_g, hist_c)), and finally publishes the
// score, bumps the BCD attempt counter and decides win/lose. Win or lose
// parks the block in OVER until reset.
//
// Ports:
//   clk          system (divided game) clock
//   reset        synchronous, active-high
//   submit       one-cycle submit pulse; ignored unless IDLE
//   guess, code  packed digits, digit k = x[k*DIGIT_W +: DIGIT_W]
//   busy         evaluation in progress (SCAN, TALLY, UPDATE)
//   result_valid one-cycle pulse when new results are written
//   n_correct    right symbol, right position
//   n_misplaced  right symbol, wrong position
//   tries_bcd    completed attempts, {tens, ones} BCD
//   win, lose    sticky game-over flags
// ---------------------------------------------------------------------------
module guess_evaluator #(
    parameter int         DIGITS        = 4,
    parameter int         DIGIT_W       = 2,
    parameter logic [7:0] MAX_TRIES_BCD = 8'h99
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      submit,
    input  logic [DIGITS*DIGIT_W-1:0] guess,
    input  logic [DIGITS*DIGIT_W-1:0] code,
    output logic                      busy,
    output logic                      result_valid,
    output logic [3:0]                n_correct,
    output logic [3:0]                n_misplaced,
    output logic [7:0]                tries_bcd,
    output logic                      win,
    output logic                      lose
);

    localparam int SYMBOLS = 2 ** DIGIT_W;
    localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int HIST_W  = $clog2(DIGITS + 1);

    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [DIGIT_W-1:0] LAST_SYM  = DIGIT_W'(SYMBOLS - 1);
    localparam logic [3:0]         ALL_RIGHT = 4'(DIGITS);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        TALLY,
        UPDATE,
        OVER
    } state_t;

    state_t state;
    state_t next_state;

    logic [DIGITS*DIGIT_W-1:0] g_q;
    logic [DIGITS*DIGIT_W-1:0] c_q;
    logic [IDX_W-1:0]          idx;
    logic [DIGIT_W-1:0]        sym;
    logic [3:0]                exact;
    logic [3:0]                sum;
    logic [HIST_W-1:0]         hist_g [SYMBOLS];
    logic [HIST_W-1:0]         hist_c [SYMBOLS];

    logic [DIGIT_W-1:0] g_dig;
    logic [DIGIT_W-1:0] c_dig;
    logic [HIST_W-1:0]  tally_min;
    logic [7:0]         tries_inc;

    // Current digit pair under SCAN, the per-symbol minimum under TALLY and
    // the BCD successor of the attempt counter. tries_inc wraps 99 -> 00 only
    // if MAX_TRIES_BCD is set above 99, since lose otherwise stops the game.
    always_comb begin
        g_dig     = g_q[idx*DIGIT_W +: DIGIT_W];
        c_dig     = c_q[idx*DIGIT_W +: DIGIT_W];
        tally_min = (hist_g[sym] < hist_c[sym]) ? hist_g[sym] : hist_c[sym];
        tries_inc = tries_bcd;
        if (tries_bcd[3:0] == 4'd9) begin
            tries_inc[3:0] = 4'd0;
            tries_inc[7:4] = (tries_bcd[7:4] == 4'd9) ? 4'd0 : tries_bcd[7:4] + 4'd1;
        end else begin
            tries_inc[3:0] = tries_bcd[3:0] + 4'd1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. Submit is only honoured in IDLE, so pulses arriving
    // mid-evaluation or after game over are simply dropped.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (submit) begin
                    next_state = SCAN;
                end
            end
            SCAN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    next_state = TALLY;
                end
            end
            TALLY: begin
                busy = 1'b1;
                if (sym == LAST_SYM) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                busy = 1'b1;
                if (exact == ALL_RIGHT) begin
                    next_state = OVER;
                end else if (tries_inc == MAX_TRIES_BCD) begin
                    next_state = OVER;
                end else begin
                    next_state = IDLE;
                end
            end
            OVER: begin
                next_state = OVER;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath. Guess and code are captured at submit so later input changes
    // cannot disturb a score in progress. The histogram sum over all symbols
    // counts every symbol match regardless of position; subtracting the exact
    // hits leaves the misplaced count, which cannot go negative because each
    // exact hit also contributes one to both histograms of its symbol.
    always_ff @(posedge clk) begin
        if (reset) begin
            g_q          <= '0;
            c_q          <= '0;
            idx          <= '0;
            sym          <= '0;
            exact        <= '0;
            sum          <= '0;
            result_valid <= 1'b0;
            n_correct    <= '0;
            n_misplaced  <= '0;
            tries_bcd    <= 8'h00;
            win          <= 1'b0;
            lose         <= 1'b0;
            for (int s = 0; s < SYMBOLS; s++) begin
                hist_g[s] <= '0;
                hist_c[s] <= '0;
            end
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (submit) begin
                        g_q   <= guess;
                        c_q   <= code;
                        idx   <= '0;
                        sym   <= '0;
                        exact <= '0;
                        sum   <= '0;
                        for (int s = 0; s < SYMBOLS; s++) begin
                            hist_g[s] <= '0;
                            hist_c[s] <= '0;
                        end
                    end
                end
                SCAN: begin
                    if (g_dig == c_dig) begin
                        exact <= exact + 4'd1;
                    end
                    hist_g[g_dig] <= hist_g[g_dig] + HIST_W'(1);
                    hist_c[c_dig] <= hist_c[c_dig] + HIST_W'(1);
                    idx           <= (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
                    sym           <= '0;
                end
                TALLY: begin
                    sum <= sum + 4'(tally_min);
                    sym <= sym + DIGIT_W'(1);
                end
                UPDATE: begin
                    n_correct    <= exact;
                    n_misplaced  <= sum - exact;
                    tries_bcd    <= tries_inc;
                    result_valid <= 1'b1;
                    if (exact == ALL_RIGHT) begin
                        win <= 1'b1;
                    end else if (tries_inc == MAX_TRIES_BCD) begin
                        lose <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/guess_evaluator.md
Name: guess_evaluator

Overview:
Sequential scoring engine for the safe-cracking game. It sits between the per-digit entry/key-handling stage and the marquee display stage.
- On a submit pulse it latches the 4-digit guess and the secret code, then scores them with mastermind rules over a fixed number of cycles.
- It keeps the BCD attempt count and raises win or lose, which freezes the game until reset.
- Its outputs drive the marquee's correct/misplaced/tries/lose inputs directly.

Parameters:
DIGITS, 4, number of code digits (the spec and tests are written for 4).
DIGIT_W, 2, bits per digit; symbol alphabet size is 2**DIGIT_W.
MAX_TRIES_BCD, 8'h99, attempt count at which a non-winning evaluation causes lose.

Ports:
clk  input  1  system clock (divided game clock).
reset  input  1  synchronous, active-high.
submit  input  1  one-cycle pulse from the submit key handler.
guess  input  DIGITS*DIGIT_W  player guess; digit k = guess[k*DIGIT_W +: DIGIT_W].
code  input  DIGITS*DIGIT_W  secret code from the LFSR, same packing.
busy  output  1  high while an evaluation is in progress.
result_valid  output  1  one-cycle pulse when new results are written.
n_correct  output  4  digits with the right symbol in the right position.
n_misplaced  output  4  digits with the right symbol in the wrong position.
tries_bcd  output  8  completed attempts, 2-digit BCD {tens, ones}.
win  output  1  sticky; set when n_correct == DIGITS.
lose  output  1  sticky; set when tries reach MAX_TRIES_BCD without a win.

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous and active-high and has priority over all other activity.
- Values after reset: state IDLE; busy=0, result_valid=0, n_correct=0, n_misplaced=0, tries_bcd=8'h00, win=0, lose=0; internal latches, histograms and accumulators cleared.
- State IDLE:
  - submit=1 at an edge E0 latches guess→g_q and code→c_q.
  - The same edge clears the exact-match count and all histogram and sum registers.
  - Next state SCAN with idx=0.
- State SCAN:
  - Runs DIGITS edges (E1..E4), one digit per edge.
  - If g_q[idx]==c_q[idx]: exact count +1.
  - Every digit: hist_g[g_q[idx]] +1 and hist_c[c_q[idx]] +1 (3-bit counters).
  - After the last digit: next state TALLY with sym=0.
- State TALLY:
  - Runs 2**DIGIT_W edges (E5..E8), one symbol per edge.
  - sum += min(hist_g[sym], hist_c[sym]).
  - After the last symbol: next state UPDATE.
- State UPDATE (edge E9):
  - n_correct ← exact count; n_misplaced ← sum − exact count (never negative by construction).
  - tries_bcd increments in BCD (ones 9→0 carries into tens, e.g. 8'h09→8'h10).
  - result_valid ← 1 for exactly one cycle.
  - If exact count==DIGITS: win←1, next state OVER.
  - Else if the incremented tries == MAX_TRIES_BCD: lose←1, next state OVER.
  - Otherwise: next state IDLE.
  - Win has priority over lose on the final attempt.
- State OVER: terminal until reset; submit is ignored; all outputs hold.
- Latency: result_valid and the new results are visible in the cycle after E9, i.e. 9 edges after the edge that sampled submit (DIGITS + 2**DIGIT_W + 1).
- busy=1 in SCAN, TALLY and UPDATE; busy=0 in IDLE and OVER.
- Submit while busy: dropped, not queued, with no effect on tries.
- Input changes after E0: guess and code changes do not affect the result in progress.
- Result holding: n_correct, n_misplaced and tries_bcd hold their last values between evaluations.
- Reset during an evaluation: the evaluation aborts immediately, no result_valid is produced, and all outputs take their reset values.
- Reset in OVER: returns to IDLE with win/lose cleared.

Test Plan:
- reset; code=8'b00011011, guess=8'b00011011, submit pulse → result_valid exactly 9 edges later; n_correct=4, n_misplaced=0, tries_bcd=8'h01, win=1; a further submit gives no result_valid.
- code=8'b00011011, guess=8'b11100100 → n_correct=0, n_misplaced=4, tries_bcd=8'h01, win=0, busy=0 after the result.
- code=8'b00000001, guess=8'b01010100 → n_correct=0, n_misplaced=2; then code=8'b00000001, guess=8'b00000000 → n_correct=3, n_misplaced=0, tries_bcd=8'h02.
- Extra submit pulses at E2 and E6 of an evaluation, and guess changed at E3 → a single result_valid; the score reflects the guess latched at E0; tries increments by 1 only.
- 99 consecutive non-winning submits → tries_bcd steps 8'h09→8'h10 at the 10th; lose=1 and tries_bcd=8'h99 at the 99th; a 100th submit → no result_valid, values held.
- reset asserted at E3 of an evaluation → next cycle busy=0 and all outputs at reset values; no result_valid pulse appears; the next submit scores normally with tries_bcd=8'h01.
